// File: rtl/regfile_writeback_unit.sv
// Register-file write-back driver: 2-entry in-order retire queue, late load-data merge, XP redirect on exception.
// Optional combinational bypass ports are built when WB_BYPASS_EN is defined.
module regfile_writeback_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int XP_REG = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rc,
    input  logic [1:0]        in_wdsel,
    input  logic              in_werf,
    input  logic              in_exc,
    input  logic [DATA_W-1:0] in_pc_plus4,
    input  logic [DATA_W-1:0] in_alu,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_werf,
    output logic              wb_wasel,
    output logic [ADDR_W-1:0] wb_wa,
    output logic [DATA_W-1:0] wb_wd,
    output logic              busy,
    output logic              mem_err
`ifdef WB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0] byp_data
`endif
);

    localparam logic [1:0]        WDSEL_PC  = 2'd0;
    localparam logic [1:0]        WDSEL_MEM = 2'd2;
    localparam logic [ADDR_W-1:0] R31       = ADDR_W'(31);

    typedef struct packed {
        logic [ADDR_W-1:0] rc;
        logic [1:0]        wdsel;
        logic              werf;
        logic              exc;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] alu;
    } entry_t;

    function automatic logic is_wait(entry_t e);
        return !e.exc && e.werf && (e.wdsel == WDSEL_MEM);
    endfunction

    entry_t            ent0_q, ent0_d, ent1_q, ent1_d, in_ent;
    logic [1:0]        count_q, count_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q;
    logic              err_q;
    logic              wb_werf_q, wb_wasel_q;
    logic [ADDR_W-1:0] wb_wa_q;
    logic [DATA_W-1:0] wb_wd_q;

    logic              head_wait, sec_wait, commit, push;
    logic              hold_set, hold_clr, err_set;
    logic [DATA_W-1:0] load_data;
    logic              wasel_d, eff_we, werf_d;
    logic [ADDR_W-1:0] wa_d;
    logic [DATA_W-1:0] wd_d;

    assign in_ready  = (count_q != 2'd2);
    assign push      = in_valid && in_ready;
    assign head_wait = (count_q != 2'd0) && is_wait(ent0_q);
    assign sec_wait  = (count_q == 2'd2) && is_wait(ent1_q);
    assign commit    = (count_q != 2'd0) && (!is_wait(ent0_q) || hold_full_q || mem_rvalid);

    // Load data belongs to the oldest waiting load; a full hold register means the data is unclaimed.
    assign hold_set  = mem_rvalid && !hold_full_q && !head_wait && sec_wait;
    assign hold_clr  = commit && head_wait && hold_full_q;
    assign err_set   = mem_rvalid && (hold_full_q || (!head_wait && !sec_wait));
    assign load_data = hold_full_q ? hold_data_q : mem_rdata;

    always_comb begin
        wasel_d = 1'b0;
        wa_d    = ent0_q.rc;
        wd_d    = ent0_q.alu;
        eff_we  = ent0_q.werf && (ent0_q.rc != R31);
        if (ent0_q.exc) begin
            wasel_d = 1'b1;
            wa_d    = ADDR_W'(XP_REG);
            wd_d    = ent0_q.pc4;
            eff_we  = 1'b1;
        end else begin
            case (ent0_q.wdsel)
                WDSEL_PC:  wd_d = ent0_q.pc4;
                WDSEL_MEM: wd_d = load_data;
                default:   wd_d = ent0_q.alu;
            endcase
        end
        werf_d = commit && eff_we;
    end

    always_comb begin
        in_ent.rc    = in_rc;
        in_ent.wdsel = in_wdsel;
        in_ent.werf  = in_werf;
        in_ent.exc   = in_exc;
        in_ent.pc4   = in_pc_plus4;
        in_ent.alu   = in_alu;
        ent0_d       = ent0_q;
        ent1_d       = ent1_q;
        if (commit) begin
            ent0_d = ent1_q;
        end
        // Incoming entry lands in the first free slot after any pop this edge.
        if (push) begin
            if ((count_q - 2'(commit)) == 2'd0) begin
                ent0_d = in_ent;
            end else begin
                ent1_d = in_ent;
            end
        end
        count_d     = count_q + 2'(push) - 2'(commit);
        hold_full_d = (hold_full_q && !hold_clr) || hold_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= 2'd0;
            hold_full_q <= 1'b0;
            err_q       <= 1'b0;
            wb_werf_q   <= 1'b0;
            wb_wasel_q  <= 1'b0;
            wb_wa_q     <= '0;
            wb_wd_q     <= '0;
        end else begin
            count_q     <= count_d;
            hold_full_q <= hold_full_d;
            err_q       <= err_q || err_set;
            wb_werf_q   <= werf_d;
            if (commit) begin
                wb_wasel_q <= wasel_d;
                wb_wa_q    <= wa_d;
                wb_wd_q    <= wd_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
        if (hold_set) begin
            hold_data_q <= mem_rdata;
        end
    end

    assign wb_werf  = wb_werf_q;
    assign wb_wasel = wb_wasel_q;
    assign wb_wa    = wb_wa_q;
    assign wb_wd    = wb_wd_q;
    assign busy     = (count_q != 2'd0) || wb_werf_q;
    assign mem_err  = err_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = werf_d;
    assign byp_addr  = wa_d;
    assign byp_data  = wd_d;
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Randomized + directed bench for regfile_writeback_unit against a queue-based reference model.
module tb_regfile_writeback_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int XP_REG = 30;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rc = '0;
    logic [1:0]        in_wdsel = '0;
    logic              in_werf = 1'b0;
    logic              in_exc = 1'b0;
    logic [DATA_W-1:0] in_pc_plus4 = '0;
    logic [DATA_W-1:0] in_alu = '0;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              wb_werf, wb_wasel, busy, mem_err;
    logic [ADDR_W-1:0] wb_wa;
    logic [DATA_W-1:0] wb_wd;

    regfile_writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .XP_REG(XP_REG)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rc(in_rc), .in_wdsel(in_wdsel), .in_werf(in_werf), .in_exc(in_exc),
        .in_pc_plus4(in_pc_plus4), .in_alu(in_alu), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_werf(wb_werf), .wb_wasel(wb_wasel), .wb_wa(wb_wa),
        .wb_wd(wb_wd), .busy(busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending instructions in order, plus early-arrived load data.
    typedef struct {
        logic [4:0]  rc;
        logic [1:0]  wdsel;
        bit          werf;
        bit          exc;
        logic [31:0] pc4;
        logic [31:0] alu;
    } ins_t;

    ins_t        mq[$];
    logic [31:0] mheld[$];
    bit          merr = 0;

    function automatic bit needs_data(ins_t e);
        return !e.exc && e.werf && e.wdsel == 2'd2;
    endfunction

    function automatic bit rv_legal();
        if (mheld.size() != 0) return 0;
        if (mq.size() > 0 && needs_data(mq[0])) return 1;
        if (mq.size() > 1 && needs_data(mq[1])) return 1;
        return 0;
    endfunction

    task automatic step(input bit v, input logic [4:0] rc, input logic [1:0] ws, input bit we,
                        input bit ex, input logic [31:0] pc4, input logic [31:0] alu,
                        input bit rv, input logic [31:0] rd);
        ins_t        h, n;
        bit          acc, com, hw, used_held, e_werf, e_wasel;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, ld;
        @(negedge clk);
        in_valid = v; in_rc = rc; in_wdsel = ws; in_werf = we; in_exc = ex;
        in_pc_plus4 = pc4; in_alu = alu; mem_rvalid = rv; mem_rdata = rd;
        #1;
        chk("in_ready", in_ready, mq.size() < 2);
        n = '{rc: rc, wdsel: ws, werf: we, exc: ex, pc4: pc4, alu: alu};
        acc = v && mq.size() < 2;
        com = 0; hw = 0; e_werf = 0; e_wasel = 0; e_wa = '0; e_wd = '0;
        if (mq.size() > 0) begin
            h   = mq[0];
            hw  = needs_data(h);
            com = !hw || mheld.size() > 0 || rv;
        end
        ld = (mheld.size() > 0) ? mheld[0] : rd;
        used_held = com && hw && mheld.size() > 0;
        if (com) begin
            if (h.exc) begin
                e_werf = 1; e_wasel = 1; e_wa = 5'(XP_REG); e_wd = h.pc4;
            end else begin
                e_wa   = h.rc;
                e_werf = h.werf && h.rc != 5'd31;
                e_wd   = (h.wdsel == 2'd0) ? h.pc4 : (h.wdsel == 2'd2) ? ld : h.alu;
            end
        end
        if (rv) begin
            if (mheld.size() > 0) merr = 1;
            else if (hw) ;
            else if (mq.size() > 1 && needs_data(mq[1])) mheld.push_back(rd);
            else merr = 1;
        end
        if (used_held) void'(mheld.pop_front());
        if (com) void'(mq.pop_front());
        if (acc) mq.push_back(n);
        @(posedge clk);
        #1;
        chk("wb_werf", wb_werf, e_werf);
        if (com) begin
            chk("wb_wasel", wb_wasel, e_wasel);
            chk("wb_wa", wb_wa, e_wa);
            chk("wb_wd", wb_wd, e_wd);
        end
        chk("busy", busy, mq.size() != 0 || e_werf);
        chk("mem_err", mem_err, merr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [4:0] rc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_werf", wb_werf, 0);
        chk("rst_wb_wasel", wb_wasel, 0);
        chk("rst_wb_wa", wb_wa, 0);
        chk("rst_wb_wd", wb_wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_err", mem_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // ALU op, load with late data and ALU behind it, exception, R31
        step(1, 5, 1, 1, 0, 32'h0, 32'h1234, 0, 0);
        idle(2);
        step(1, 7, 2, 1, 0, 32'h40, 32'h0, 0, 0);
        step(1, 8, 1, 1, 0, 32'h44, 32'h77, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        idle(2);
        step(1, 4, 2, 0, 1, 32'h100, 32'h0, 0, 0);
        idle(2);
        step(1, 31, 1, 1, 0, 32'h0, 32'h55, 0, 0);
        idle(2);

        // Randomized traffic; load data only where a waiting load can take it
        for (int i = 0; i < 1500; i++) begin
            bit rv;
            rc = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
            rv = rv_legal() && ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 1), rc, 2'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom, $urandom, rv, $urandom);
        end
        while (mq.size() != 0) begin
            step(0, 0, 0, 0, 0, 0, 0, rv_legal(), $urandom);
        end
        idle(1);

        // Two loads fill the queue, third request stalls; data returns in order
        step(1, 10, 2, 1, 0, 32'h0, 32'h0, 0, 0);
        step(1, 11, 2, 1, 0, 32'h0, 32'h0, 0, 0);
        step(1, 12, 1, 1, 0, 32'h0, 32'h9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hA);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hB);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hC);
        idle(2);

        // Reset asserted while a write is on the outputs and an entry is pending
        step(1, 13, 2, 1, 0, 32'h0, 32'h0, 0, 0);
        step(1, 14, 1, 1, 0, 32'h0, 32'h66, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111);
        #2;
        reset_n = 1'b0;
        in_valid = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk("midrst_wb_werf", wb_werf, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_err", mem_err, 0);
        chk("midrst_in_ready", in_ready, 1);
        mq.delete();
        mheld.delete();
        merr = 0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
